gate_model_bist: RTL

- Parametrised built-in self-test wrapper for the combinational gate-model netlists in the simulator gate library.
- An LFSR generates the input patterns and drives them into the gate model. A MISR compacts the model's outputs into a signature.
- After a programmable pattern count, the signature is compared against an expected value and a pass/done result is reported.
- Generalises the fixed 15-in/10-out gate models to any input/output width, with a multi-cycle settle time per pattern.

---
 rtl/gate_model_bist.sv | 121 ++++++++++++
 1 files changed

// File: rtl/gate_model_bist.sv
// BIST wrapper for combinational gate models: an LFSR drives patterns and a MISR
// compacts the responses, then the signature is checked against a golden value.
module gate_model_bist #(
    parameter int              N_IN       = 15,
    parameter int              N_OUT      = 10,
    parameter int              PATTERNS   = 256,
    parameter int              SETTLE_CYC = 1,
    parameter logic [N_IN-1:0]  LFSR_SEED  = 15'h0001,
    parameter logic [N_IN-1:0]  LFSR_TAPS  = 15'h6000,
    parameter logic [N_OUT-1:0] MISR_TAPS  = 10'h240,
    localparam int             CNT_W      = $clog2(PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] expected_sig,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_OUT-1:0] signature,
    output logic [CNT_W-1:0] pattern_cnt
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(PATTERNS);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [N_IN-1:0]  SEED = (LFSR_SEED == '0) ? {{(N_IN-1){1'b0}}, 1'b1} : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    lfsr_q, lfsr_d;
    logic [N_OUT-1:0]   misr_q, misr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic               pass_q, pass_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            set_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
            pass_q  <= pass_d;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign capture = (set_q == SET_LAST);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        set_d   = set_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    lfsr_d  = SEED;
                    misr_d  = '0;
                    cnt_d   = '0;
                    set_d   = '0;
                    pass_d  = 1'b0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                // Abort wins over a capture falling in the same cycle.
                if (abort) begin
                    set_d   = '0;
                    state_d = IDLE;
                end else if (capture) begin
                    misr_d = {misr_q[N_OUT-2:0], ^(misr_q & MISR_TAPS)} ^ dut_out;
                    lfsr_d = {lfsr_q[N_IN-2:0], ^(lfsr_q & LFSR_TAPS)};
                    cnt_d  = cnt_inc;
                    set_d  = '0;
                    if (cnt_inc == PAT_LAST) begin
                        state_d = FINISH;
                    end
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            FINISH: begin
                pass_d  = (misr_q == expected_sig);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dut_in      = (state_q == APPLY) ? lfsr_q : '0;
    assign busy        = (state_q == APPLY);
    assign done        = (state_q == FINISH);
    assign pass        = pass_q;
    assign signature   = misr_q;
    assign pattern_cnt = cnt_q;

endmodule
